score_lives_keeper: RTL

Game-state bookkeeping stage that sits directly upstream of the top-level seven-segment scan logic. It accepts single-cycle hit/miss event pulses from the game logic and a raw start button. It maintains a two-digit BCD score (00–99) and a lives counter, and produces the `score_ones`, `score_tens` and `lives` nibbles that the SSD scanner displays. It also runs the IDLE/PLAY/OVER game-phase state machine, so the block controller can gate motion and rendering on `playing`/`game_over`.

---
 rtl/score_lives_keeper.sv | 130 +++++++++++++
 1 files changed

// File: rtl/score_lives_keeper.sv
// score_lives_keeper: two-digit BCD score, lives counter and the
// IDLE/PLAY/OVER game-phase FSM that feeds the seven-segment scanner.
module score_lives_keeper #(
  parameter int unsigned INIT_LIVES = 3,
  parameter int unsigned MAX_LIVES  = 9,
  parameter bit          BONUS_EN   = 1'b1
) (
  input  logic       ClkPort,
  input  logic       Reset_n,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score_ones,
  output logic [3:0] score_tens,
  output logic [3:0] lives,
  output logic       playing,
  output logic       game_over,
  output logic       life_lost
);

  localparam logic [3:0] INIT_L = 4'(INIT_LIVES);
  localparam logic [3:0] MAX_L  = 4'(MAX_LIVES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] lives_q, lives_d;
  logic       life_lost_q, life_lost_d;
  logic       playing_q, game_over_q;
  logic       sync1_q, sync2_q, sync_dly_q;
  logic       start_re;
  logic       bonus;
  logic       gain;

  // Synchronize the raw start button and keep a delayed copy for edge detection.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync_dly_q <= 1'b0;
    end else begin
      sync1_q    <= start;
      sync2_q    <= sync1_q;
      sync_dly_q <= sync2_q;
    end
  end

  assign start_re = sync2_q & ~sync_dly_q;

  // Game state, score, lives and registered status outputs.
  always_ff @(posedge ClkPort or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      ones_q      <= '0;
      tens_q      <= '0;
      lives_q     <= INIT_L;
      life_lost_q <= 1'b0;
      playing_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
      lives_q     <= lives_d;
      life_lost_q <= life_lost_d;
      playing_q   <= (state_d == PLAY);
      game_over_q <= (state_d == OVER);
    end
  end

  // Next-state: phase transitions, BCD score increment and net lives change.
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    tens_d      = tens_q;
    lives_d     = lives_q;
    life_lost_d = 1'b0;
    bonus       = 1'b0;
    gain        = 1'b0;
    unique case (state_q)
      IDLE, OVER: begin
        if (start_re) begin
          state_d = PLAY;
          ones_d  = '0;
          tens_d  = '0;
          lives_d = INIT_L;
        end
      end
      PLAY: begin
        if (hit) begin
          if (ones_q != 4'd9) begin
            ones_d = ones_q + 4'd1;
          end else if (tens_q != 4'd9) begin
            ones_d = '0;
            tens_d = tens_q + 4'd1;
            bonus  = 1'b1;
          end
        end
        gain = BONUS_EN & bonus;
        // A bonus and a miss on the same cycle cancel: no change, no pulse.
        if (gain && !miss) begin
          if (lives_q < MAX_L) begin
            lives_d = lives_q + 4'd1;
          end
        end else if (!gain && miss) begin
          lives_d     = lives_q - 4'd1;
          life_lost_d = 1'b1;
          if (lives_q == 4'd1) begin
            state_d = OVER;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign score_ones = ones_q;
  assign score_tens = tens_q;
  assign lives      = lives_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign life_lost  = life_lost_q;

endmodule
